// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg
// Shared type definitions for the RV32IMA core.
// Holds the ALU op encodings, the M-extension operation encoding used by
// muldiv_unit, the muldiv_unit FSM state type, and small op-decode helpers.
// No ports (package).

package rv32ima_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Encoding follows the RV32M funct3 order, so bit 2 marks the divide
    // group and bit 1 within that group marks the remainder ops.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(muldiv_op_t op);
        return op[2] && op[1];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed1(muldiv_op_t op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic op_signed2(muldiv_op_t op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Request/response bundle between a requester and muldiv_unit.
//   flush      : requester -> unit, abort any operation in flight
//   req_valid  : requester -> unit, request present
//   req_ready  : unit -> requester, unit can accept a request
//   op         : requester -> unit, muldiv operation
//   in1 / in2  : requester -> unit, rs1 / rs2 operands
//   resp_valid : unit -> requester, result present
//   resp_ready : requester -> unit, consumer takes result
//   out        : unit -> requester, result
//   busy       : unit -> requester, unit not idle
// Modports: master (requester side), slave (unit side).

interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    import rv32ima_pkg::*;

    logic            flush;
    logic            req_valid;
    logic            req_ready;
    muldiv_op_t      op;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] out;
    logic            busy;

    modport master (
        output flush, req_valid, op, in1, in2, resp_ready,
        input  req_ready, resp_valid, out, busy
    );

    modport slave (
        input  flush, req_valid, op, in1, in2, resp_ready,
        output req_ready, resp_valid, out, busy
    );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit. One result bit is retired per cycle
// through a single XLEN+1-bit adder/subtractor: shift-add for multiplies,
// restoring division for divides. Operands are converted to magnitudes on
// accept and the sign is restored in a one-cycle FIX step. Divide-by-zero
// and signed overflow are resolved at accept and skip straight to DONE.
// Ports:
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : muldiv_unit_if slave (flush, request, response, busy)

module muldiv_unit
    import rv32ima_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN) + 1;

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              in1_neg, in2_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     add_x, add_y, add_cin, add_sum;
    logic              q_bit;
    logic [2*XLEN-1:0] fix_src, fix_val;

    // Decode the incoming request: operand signs under the op's signedness,
    // magnitudes, and the two divide cases that need no iteration.
    always_comb begin
        in1_neg  = op_signed1(bus.op) && bus.in1[XLEN-1];
        in2_neg  = op_signed2(bus.op) && bus.in2[XLEN-1];
        mag1     = in1_neg ? -bus.in1 : bus.in1;
        mag2     = in2_neg ? -bus.in2 : bus.in2;
        div_zero = op_is_div(bus.op) && (bus.in2 == '0);
        div_ovf  = op_is_div(bus.op) && op_signed2(bus.op)
                   && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.in2 == '1);
    end

    // The single shared adder. In divide mode it subtracts the divisor from
    // the shifted partial remainder; a clear top bit means the trial
    // subtraction fits and the quotient bit is 1. In multiply mode it adds
    // the multiplicand into the upper product half when the current
    // multiplier bit is set.
    always_comb begin
        if (op_is_div(op_q)) begin
            add_x   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
            add_y   = ~{1'b0, b_q};
            add_cin = {{XLEN{1'b0}}, 1'b1};
        end else begin
            add_x   = {1'b0, acc_q[2*XLEN-1:XLEN]};
            add_y   = b_q[0] ? {1'b0, a_q} : '0;
            add_cin = '0;
        end
        add_sum = add_x + add_y + add_cin;
        q_bit   = ~add_sum[XLEN];
    end

    // Sign restoration: pick the raw magnitude result and negate it when the
    // latched result sign is set. The product is negated at full width so
    // the high half of a signed product comes out right.
    always_comb begin
        case (op_q)
            DIV, DIVU: fix_src = {{XLEN{1'b0}}, a_q};
            REM, REMU: fix_src = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
            default:   fix_src = acc_q;
        endcase
        fix_val = neg_q ? -fix_src : fix_src;
    end

    // Next-state and datapath update. Flush wins over everything else,
    // including an accept in the same cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        if (bus.flush) begin
            state_d = IDLE;
            res_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_d  = bus.op;
                        a_d   = mag1;
                        b_d   = mag2;
                        acc_d = '0;
                        cnt_d = CW'(XLEN);
                        neg_d = op_is_rem(bus.op) ? in1_neg : (in1_neg ^ in2_neg);
                        if (div_zero) begin
                            res_d   = op_is_rem(bus.op) ? bus.in1 : '1;
                            state_d = DONE;
                        end else if (div_ovf) begin
                            res_d   = op_is_rem(bus.op) ? '0 : bus.in1;
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_d = cnt_q - CW'(1);
                    if (op_is_div(op_q)) begin
                        acc_d = {{(XLEN-1){1'b0}}, q_bit ? add_sum : add_x};
                        a_d   = {a_q[XLEN-2:0], q_bit};
                    end else begin
                        acc_d = {add_sum, acc_q[XLEN-1:1]};
                        b_d   = {1'b0, b_q[XLEN-1:1]};
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    res_d   = (op_q inside {MULH, MULHSU, MULHU})
                              ? fix_val[2*XLEN-1:XLEN] : fix_val[XLEN-1:0];
                    state_d = DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset that overrides
    // flush and any request.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= MUL;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.out        = (state_q == DONE) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit at XLEN=32. A driver issues directed
// requests and queues the hand-computed result and latency; a monitor pops
// and compares on every rising resp_valid. Directed sections cover response
// stalling, flush mid-CALC and reset mid-CALC.
// No ports (top-level bench).

`timescale 1ns/1ps

module tb_muldiv_unit;
    import rv32ima_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic nRST;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] result;
        int          latency;
        int          acceptEdge;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   applied     = 0;
    int   miscompares = 0;
    int   cycleCount  = 0;
    int   respCount   = 0;

    // Count rising edges so latency can be measured from the accept edge.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called on a falling edge; drives one request for one cycle and, when
    // tracked, queues its expected result and latency.
    task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expRes,
                                 input int expLat, input string name, input bit track);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s_ready_timeout: req_ready stayed 0, expected 1", name);
        end
        bus.op        = op;
        bus.in1       = a;
        bus.in2       = b;
        bus.req_valid = 1'b1;
        if (track) expQ.push_back('{expRes, expLat, cycleCount + 1, name});
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s_idle_timeout: busy stayed 1, expected 0", name);
        end
    endtask

    task automatic runVector(input muldiv_op_t op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expRes,
                             input int expLat, input string name);
        applyStimulus(op, a, b, expRes, expLat, name, 1'b1);
        waitIdle(name);
    endtask

    // Monitor: compare every new response against the head of the queue.
    initial begin : monitor
        logic prevValid;
        exp_t e;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.resp_valid && !prevValid) begin
                respCount++;
                if (expQ.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_response: got 0x%08h, expected no response", bus.out);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, "_out"}, bus.out, e.result);
                    checkOutput({e.name, "_latency"}, 32'(cycleCount - e.acceptEdge + 1),
                                32'(e.latency));
                end
            end
            prevValid = bus.resp_valid;
        end
    end

    // Driver: reset, directed vectors, then the stall, flush and reset paths.
    initial begin : driver
        int n;
        int respBefore;

        nRST           = 1'b0;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.op         = MUL;
        bus.in1        = '0;
        bus.in2        = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("reset_out", bus.out, 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);

        runVector(DIV,    32'd20,         32'hFFFFFFFD, 32'hFFFFFFFA, 34, "div_20_m3");
        runVector(REM,    32'd20,         32'hFFFFFFFD, 32'h00000002, 34, "rem_20_m3");
        runVector(DIVU,   32'd7,          32'd0,        32'hFFFFFFFF, 1,  "divu_by_zero");
        runVector(REMU,   32'd7,          32'd0,        32'h00000007, 1,  "remu_by_zero");
        runVector(DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  "div_overflow");
        runVector(REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1,  "rem_overflow");
        runVector(MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 34, "mulh_m1_m1");
        runVector(MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
        runVector(MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1_max");
        runVector(MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 34, "mul_max");
        runVector(MUL,    32'd6,          32'd7,        32'd42,       34, "mul_6_7");
        runVector(DIVU,   32'd100,        32'd7,        32'd14,       34, "divu_100_7");
        runVector(REMU,   32'd100,        32'd7,        32'd2,        34, "remu_100_7");
        runVector(DIV,    32'hFFFFFFEC,   32'd3,        32'hFFFFFFFA, 34, "div_m20_3");
        runVector(REM,    32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, 34, "rem_m20_3");
        runVector(MULH,   32'h80000000,   32'd2,        32'hFFFFFFFF, 34, "mulh_min_2");
        runVector(REM,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, 1,  "rem_by_zero");
        runVector(DIV,    32'h80000000,   32'd1,        32'h80000000, 34, "div_min_1");

        // Consumer stall: result must hold while resp_ready is low, and a
        // request presented meanwhile must be ignored.
        bus.resp_ready = 1'b0;
        applyStimulus(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "stall_mulhu", 1'b1);
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_resp_seen", 32'(bus.resp_valid), 32'd1);
        bus.op        = DIVU;
        bus.in1       = 32'd9;
        bus.in2       = 32'd0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_out", bus.out, 32'hFFFFFFFE);
            checkOutput("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall_release_busy", 32'(bus.busy), 32'd0);
        checkOutput("stall_release_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("stall_release_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);

        // Flush at CALC cycle 10 with a competing request.
        applyStimulus(DIV, 32'd100, 32'd7, 32'd0, 0, "flushed_div", 1'b0);
        repeat (9) @(negedge clk);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.op        = MUL;
        bus.in1       = 32'd3;
        bus.in2       = 32'd5;
        @(posedge clk);
        #1;
        checkOutput("flush_busy", 32'(bus.busy), 32'd0);
        checkOutput("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("flush_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("flush_out", bus.out, 32'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        checkOutput("flush_request_dropped", 32'(bus.busy), 32'd0);
        respBefore = respCount;
        repeat (40) @(negedge clk);
        checkOutput("flush_no_response", 32'(respCount), 32'(respBefore));

        // Reset mid-CALC, with flush and a request also asserted.
        applyStimulus(DIVU, 32'd1000, 32'd3, 32'd0, 0, "reset_divu", 1'b0);
        repeat (5) @(negedge clk);
        nRST          = 1'b0;
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("midreset_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("midreset_out", bus.out, 32'd0);
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        nRST          = 1'b1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        respBefore = respCount;
        repeat (40) @(negedge clk);
        checkOutput("midreset_no_response", 32'(respCount), 32'(respBefore));

        runVector(MUL, 32'd12, 32'd11, 32'd132, 34, "mul_after_reset");
        repeat (2) @(negedge clk);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: CLK and nRST.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the operand/result width; legal values are even and at least 4.
REQ-003 The block SHALL have these ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- flush  in  1  abort any operation in flight
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- op  in  muldiv_op_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- in1  in  XLEN  rs1 operand (dividend / multiplicand)
- in2  in  XLEN  rs2 operand (divisor / multiplier)
- resp_valid  out  1  result present
- resp_ready  in  1  consumer takes result
- out  out  XLEN  result
- busy  out  1  state is not IDLE

Function
REQ-004 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-005 req_ready SHALL equal (state==IDLE); a request is accepted on a rising edge with req_valid&&req_ready.
REQ-006 On accept, the unit SHALL latch op, the operand magnitudes and the result sign, clear the accumulator, load the iteration counter with XLEN, and go to CALC.
REQ-007 Special cases SHALL be detected at accept and go directly to DONE, bypassing CALC and FIX:
- divisor==0: DIV/DIVU give all-ones; REM/REMU give in1.
- signed overflow (DIV/REM, in1 = minimum signed, in2 = -1): DIV gives in1; REM gives 0.
REQ-008 CALC SHALL retire one bit per cycle for XLEN cycles:
- Multiply: shift-add on magnitudes into a 2*XLEN-bit product.
- Divide: restoring division, XLEN+1-bit partial remainder.
REQ-009 Operand signedness SHALL be:
- MULH, DIV, REM: both operands signed.
- MULHSU: in1 signed, in2 unsigned.
- MULHU, DIVU, REMU: both unsigned.
- MUL: sign-agnostic (low half).
REQ-010 FIX SHALL last one cycle and apply two's-complement negation where required:
- Product sign = sign(in1) XOR sign(in2).
- Quotient sign = sign(in1) XOR sign(in2).
- Remainder sign = sign(in1).
FIX then selects the product low half (MUL), product high half (MULH*), quotient or remainder.
REQ-011 Latency SHALL be as follows:
- resp_valid rises exactly XLEN+2 cycles after the accept edge for computed operations.
- resp_valid rises 1 cycle after the accept edge for special cases.
REQ-012 In DONE, resp_valid SHALL be 1 and out SHALL hold stable until the edge with resp_ready=1, after which state returns to IDLE.
- A new request can be accepted no earlier than the following cycle (no same-cycle turnaround).
REQ-013 out SHALL be 0 and resp_valid SHALL be 0 in every state other than DONE.
REQ-014 flush=1 SHALL, on the next edge, force IDLE, drop resp_valid and discard the result from any state.
- flush has priority over an accept in the same cycle; the request is not taken.
REQ-015 The iteration counter SHALL be $clog2(XLEN)+1 bits wide, decrement only in CALC, and leave CALC when it reaches 1 (no wrap).
REQ-016 req_valid while busy SHALL be ignored with no effect on latched operands.

Reset
REQ-017 With nRST=0 at an edge, the unit SHALL reach the following values:
- state = IDLE, counter = 0, accumulators = 0.
- Outputs: req_ready=1, resp_valid=0, out=0, busy=0.
REQ-018 Reset SHALL override flush and any request, including mid-CALC.

Structure
REQ-019 muldiv_op_t (3-bit enum) and the state enum muldiv_state_t SHALL be defined in rv32ima_pkg, alongside the existing ALU op encodings.
REQ-020 The block SHALL be a single module with no sub-module; the FSM and datapath are sized by XLEN only.
REQ-021 The datapath SHALL have no combinational multiplier or divider; each cycle uses one XLEN+1-bit adder/subtractor.

Verification (XLEN=32)
REQ-022 The bench SHALL cover DIV 20 / -3: result 0xFFFFFFFA; REM of the same operands gives 0x00000002; resp_valid arrives at exactly 34 cycles.
REQ-023 The bench SHALL cover DIVU 7 / 0: result 0xFFFFFFFF, resp_valid after 1 cycle; REMU 7 / 0 gives 0x00000007.
REQ-024 The bench SHALL cover DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000; REM of the same operands gives 0 (both special-case path).
REQ-025 The bench SHALL cover in1=in2=0xFFFFFFFF under each multiply op:
- MULH gives 0x00000000.
- MULHU gives 0xFFFFFFFE.
- MULHSU gives 0xFFFFFFFF.
- MUL gives 0x00000001.
REQ-026 The bench SHALL hold resp_ready=0 for 5 cycles after resp_valid and check that out, resp_valid and req_ready=0 stay stable; it then pulses resp_ready and checks IDLE on the next edge.
REQ-027 The bench SHALL cover the abort paths:
- Assert flush at CALC cycle 10 with req_valid=1: next edge is IDLE, resp_valid=0, no response ever issues.
- Separately, assert nRST=0 mid-CALC: all outputs reach reset values.
